core_dma: RTL and testbench

Single-channel word DMA engine sitting directly downstream of the core's EX-stage DMA interface. It consumes the one-cycle DMA command (funct3, imm, rs1, rs2), drives the `dma_busy_i` stall input back into the core, and masters the shared data-memory port through the dmem arbiter while the core is stalled. It performs word-granular memory-to-memory copy and, optionally, memory fill.

---
 rtl/core_dma.sv | 214 +++++++++++++++++++++
 tb/tb_core_dma.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dma.sv
// core_dma: single-channel word DMA engine mastering the dmem port while the core stalls.
// Performs word-granular memory-to-memory COPY; memory FILL is optional and is
// built only when the macro CORE_DMA_FILL_EN is defined (otherwise funct3 001 is illegal).
module core_dma #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LEN_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dma_en_i,
    input  logic [2:0]       dma_funct3_i,
    input  logic [LEN_W-1:0] dma_imm_i,
    input  logic [XLEN-1:0]  dma_rs1_i,
    input  logic [XLEN-1:0]  dma_rs2_i,
    output logic             dma_busy_o,
    output logic             dma_done_o,
    output logic             dma_err_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wr_data_o,
    input  logic [XLEN-1:0]  mem_rd_data_i,
    output logic [3:0]       mem_size_o,
    output logic             mem_read_o,
    output logic             mem_write_o
);

    localparam logic [2:0]       F3_COPY   = 3'b000;
`ifdef CORE_DMA_FILL_EN
    localparam logic [2:0]       F3_FILL   = 3'b001;
`endif
    localparam logic [XLEN-1:0]  WORD_STEP = XLEN'(4);
    localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_ZERO  = LEN_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   dst_q, dst_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
`ifdef CORE_DMA_FILL_EN
    logic              op_q, op_d;        // 1: FILL, 0: COPY
`endif

    logic              cmd_legal_c;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        size_q, size_d;

    // Command decode: which funct3 codes this build accepts
    always_comb begin
        cmd_legal_c = (dma_funct3_i == F3_COPY);
`ifdef CORE_DMA_FILL_EN
        cmd_legal_c = cmd_legal_c || (dma_funct3_i == F3_FILL);
`endif
    end

    // Next-state, datapath and next-output computation
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
`ifdef CORE_DMA_FILL_EN
        op_d    = op_q;
`endif
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dma_en_i) begin
                    if (!cmd_legal_c) begin
                        err_d = 1'b1;
                    end else if (dma_imm_i == CNT_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        src_d = {dma_rs1_i[XLEN-1:2], 2'b00};
                        dst_d = {dma_rs2_i[XLEN-1:2], 2'b00};
                        cnt_d = dma_imm_i;
`ifdef CORE_DMA_FILL_EN
                        // FILL writes the raw rs1 value, so preload it into buf
                        buf_d   = dma_rs1_i;
                        op_d    = (dma_funct3_i == F3_FILL);
                        state_d = op_d ? ST_WR : ST_RD;
`else
                        state_d = ST_RD;
`endif
                    end
                end
            end

            ST_RD: begin
                if (mem_gnt_i) begin
                    state_d = ST_CAP;
                end
            end

            ST_CAP: begin
                // Read data arrives one cycle after the granted read
                buf_d   = mem_rd_data_i;
                state_d = ST_WR;
            end

            ST_WR: begin
                if (mem_gnt_i) begin
                    src_d = src_q + WORD_STEP;
                    dst_d = dst_q + WORD_STEP;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
`ifdef CORE_DMA_FILL_EN
                        state_d = op_q ? ST_WR : ST_RD;
`else
                        state_d = ST_RD;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so they are registered yet
        // line up with the state they belong to; ungranted cycles hold all inputs
        // to this decode, keeping the request stable.
        busy_d  = (state_d != ST_IDLE);
        read_d  = (state_d == ST_RD);
        write_d = (state_d == ST_WR);
        req_d   = read_d || write_d;
        size_d  = {4{req_d}};

        if (read_d) begin
            addr_d = src_d;
        end else if (write_d) begin
            addr_d = dst_d;
        end else begin
            addr_d = '0;
        end

        wdata_d = write_d ? buf_d : '0;
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
`ifdef CORE_DMA_FILL_EN
            op_q    <= 1'b0;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
`ifdef CORE_DMA_FILL_EN
            op_q    <= op_d;
`endif
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
        end
    end

    assign dma_busy_o    = busy_q;
    assign dma_done_o    = done_q;
    assign dma_err_o     = err_q;
    assign mem_req_o     = req_q;
    assign mem_read_o    = read_q;
    assign mem_write_o   = write_q;
    assign mem_addr_o    = addr_q;
    assign mem_wr_data_o = wdata_q;
    assign mem_size_o    = size_q;

endmodule

// File: tb/tb_core_dma.sv
// Testbench for core_dma: directed vector table, hand-written corner sequences and
// randomized commands checked against a word-level transfer model.
module tb_core_dma;

    localparam int NVEC = 9;
`ifdef CORE_DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dma_en_i = 1'b0;
    logic [2:0]  dma_funct3_i = 3'b000;
    logic [11:0] dma_imm_i = 12'd0;
    logic [31:0] dma_rs1_i = 32'h0;
    logic [31:0] dma_rs2_i = 32'h0;
    logic        dma_busy_o, dma_done_o, dma_err_o;
    logic        mem_req_o, mem_read_o, mem_write_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o, mem_wr_data_o;
    logic [31:0] mem_rd_data_i = 32'h0;
    logic [3:0]  mem_size_o;

    core_dma #(.XLEN(32), .LEN_W(12)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .dma_en_i      (dma_en_i),
        .dma_funct3_i  (dma_funct3_i),
        .dma_imm_i     (dma_imm_i),
        .dma_rs1_i     (dma_rs1_i),
        .dma_rs2_i     (dma_rs2_i),
        .dma_busy_o    (dma_busy_o),
        .dma_done_o    (dma_done_o),
        .dma_err_o     (dma_err_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .mem_rd_data_i (mem_rd_data_i),
        .mem_size_o    (mem_size_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          d0, d1, d2, d3;   // grant-low cycles for the first four requests
        int          busy;
        int          done;
        int          err;
    } vec_t;

    vec_t tab[NVEC];

    // Memory / arbiter environment state
    bit [31:0] mem [bit [31:0]];
    bit [31:0] wr_a[$];
    bit [31:0] wr_d[$];
    int        deny_q[$];
    int        deny_left = 0;
    bit        new_req = 1'b1;
    bit        acc_pend = 1'b0, acc_wr = 1'b0, rd_pend = 1'b0;
    bit [31:0] acc_addr, acc_data, rd_addr;
    bit        prev_req = 1'b0, prev_gnt = 1'b0, prev_rst = 1'b0;
    logic [66:0] prev_vec = '0;

    int busy_cyc = 0, done_cnt = 0, err_cnt = 0;
    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit [31:0] rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic bit legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (FILL_EN && f3 == 3'b001);
    endfunction

    // Word-level expectation: sequential read-then-write per word on a memory copy
    function automatic void model_writes(input logic [2:0] f3, input logic [11:0] imm,
                                         input logic [31:0] rs1, input logic [31:0] rs2,
                                         output bit [31:0] ea[$], output bit [31:0] ed[$]);
        bit [31:0] mm [bit [31:0]];
        bit [31:0] s, d, v;
        ea.delete();
        ed.delete();
        if (!legal(f3)) return;
        mm = mem;
        s = rs1 & ~32'h3;
        d = rs2 & ~32'h3;
        for (int i = 0; i < int'(imm); i++) begin
            if (f3 == 3'b000) v = mm.exists(s) ? mm[s] : 32'h0;
            else              v = rs1;
            mm[d] = v;
            ea.push_back(d);
            ed.push_back(v);
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endfunction

    // One clock: commit the access granted for this edge, then monitor and arbitrate
    task automatic cycle();
        @(posedge clk_i);
        #1;
        rd_pend = 1'b0;
        if (rst_ni && acc_pend) begin
            if (acc_wr) begin
                mem[acc_addr] = acc_data;
                wr_a.push_back(acc_addr);
                wr_d.push_back(acc_data);
            end else begin
                rd_pend = 1'b1;
                rd_addr = acc_addr;
            end
        end
        acc_pend = 1'b0;
        @(negedge clk_i);
        if (dma_busy_o) busy_cyc++;
        if (dma_done_o) done_cnt++;
        if (dma_err_o)  err_cnt++;
        if (dma_done_o) chk("done_with_busy_low", dma_busy_o, 1'b0);
        if (mem_req_o)
            chk("req_shape", {mem_addr_o[1:0], mem_size_o, mem_read_o ^ mem_write_o}, {2'b00, 4'hF, 1'b1});
        else
            chk("idle_quiet", {mem_size_o, mem_read_o, mem_write_o}, 6'h0);
        if (rst_ni && prev_rst && prev_req && !prev_gnt)
            chk("hold_while_ungranted", {mem_req_o, mem_read_o, mem_write_o, mem_addr_o, mem_wr_data_o}, prev_vec);
        if (!rst_ni) begin
            new_req = 1'b1;
            deny_left = 0;
            mem_gnt_i = 1'b0;
        end else if (mem_req_o) begin
            if (new_req) begin
                deny_left = 0;
                if (deny_q.size() > 0) deny_left = deny_q.pop_front();
                new_req = 1'b0;
            end
            if (deny_left > 0) begin
                mem_gnt_i = 1'b0;
                deny_left--;
            end else begin
                mem_gnt_i = 1'b1;
                new_req = 1'b1;
                acc_pend = 1'b1;
                acc_wr = mem_write_o;
                acc_addr = mem_addr_o;
                acc_data = mem_wr_data_o;
            end
        end else begin
            mem_gnt_i = 1'b0;
        end
        mem_rd_data_i = rd_pend ? rd(rd_addr) : $urandom;
        prev_req = mem_req_o;
        prev_gnt = mem_gnt_i;
        prev_rst = rst_ni;
        prev_vec = {mem_req_o, mem_read_o, mem_write_o, mem_addr_o, mem_wr_data_o};
    endtask

    task automatic run_cmd(input string name, input logic [2:0] f3, input logic [11:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input int exp_busy, input int exp_done, input int exp_err, input bit inject);
        bit [31:0] ea[$];
        bit [31:0] ed[$];
        int b;
        int n0;
        model_writes(f3, imm, rs1, rs2, ea, ed);
        n0 = wr_a.size();
        busy_cyc = 0;
        done_cnt = 0;
        err_cnt = 0;
        dma_en_i = 1'b1;
        dma_funct3_i = f3;
        dma_imm_i = imm;
        dma_rs1_i = rs1;
        dma_rs2_i = rs2;
        cycle();
        dma_en_i = 1'b0;
        if (exp_busy > 0)
            chk({name, ":busy_rise"}, dma_busy_o, 1'b1);
        else
            chk({name, ":first_cycle"}, {dma_busy_o, dma_done_o, dma_err_o},
                {1'b0, 1'(exp_done), 1'(exp_err)});
        b = 0;
        while (dma_busy_o && b < 4000) begin
            if (inject && b == 0) begin
                dma_en_i = 1'b1;
                dma_funct3_i = 3'b001;
                dma_imm_i = 12'd7;
                dma_rs1_i = $urandom;
                dma_rs2_i = $urandom;
            end else begin
                dma_en_i = 1'b0;
            end
            cycle();
            b++;
        end
        dma_en_i = 1'b0;
        chk({name, ":terminated"}, dma_busy_o, 1'b0);
        cycle();
        cycle();
        chk({name, ":busy_cycles"}, busy_cyc, exp_busy);
        chk({name, ":done_pulses"}, done_cnt, exp_done);
        chk({name, ":err_pulses"}, err_cnt, exp_err);
        chk({name, ":write_count"}, wr_a.size() - n0, ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (n0 + i < wr_a.size())
                chk($sformatf("%s:write%0d", name, i), {wr_a[n0+i], wr_d[n0+i]}, {ea[i], ed[i]});
        end
        deny_q.delete();
    endtask

    logic [2:0]  rf3;
    logic [11:0] rimm;
    logic [31:0] rrs1, rrs2;
    int          eb, nreq, dd, bb;
    bit          lg;

    initial begin
        // Directed table: {f3, imm, rs1, rs2, deny0..3, busy, done, err}
        tab[0] = '{3'b000, 12'd4, 32'h0000_0100, 32'h0000_0200, 0, 0, 0, 0, 12, 1, 0};
        tab[1] = '{3'b001, 12'd3, 32'hDEAD_BEEF, 32'h0000_0303, 0, 0, 0, 0,
                   FILL_EN ? 3 : 0, FILL_EN ? 1 : 0, FILL_EN ? 0 : 1};
        tab[2] = '{3'b000, 12'd2, 32'h0000_0400, 32'h0000_0500, 5, 0, 0, 3, 14, 1, 0};
        tab[3] = '{3'b000, 12'd0, 32'h0000_0100, 32'h0000_0600, 0, 0, 0, 0, 0, 1, 0};
        tab[4] = '{3'b101, 12'd2, 32'h0000_0100, 32'h0000_0600, 0, 0, 0, 0, 0, 0, 1};
        tab[5] = '{3'b000, 12'd2, 32'h0000_0100, 32'hFFFF_FFFC, 0, 0, 0, 0, 6, 1, 0};
        tab[6] = '{3'b111, 12'd0, 32'h0000_0100, 32'h0000_0600, 0, 0, 0, 0, 0, 0, 1};
        tab[7] = '{3'b000, 12'd1, 32'h0000_0103, 32'h0000_0803, 0, 0, 0, 0, 3, 1, 0};
        tab[8] = '{3'b001, 12'd3, 32'h1234_5678, 32'h0000_0A00, 2, 0, 1, 0,
                   FILL_EN ? 6 : 0, FILL_EN ? 1 : 0, FILL_EN ? 0 : 1};

        mem[32'h100] = 32'hA0A0_0001;
        mem[32'h104] = 32'hB0B0_0002;
        mem[32'h108] = 32'hC0C0_0003;
        mem[32'h10C] = 32'hD0D0_0004;
        mem[32'h400] = 32'h4444_0000;
        mem[32'h404] = 32'h4444_0004;

        repeat (3) cycle();
        chk("reset_outputs",
            {dma_busy_o, dma_done_o, dma_err_o, mem_req_o, mem_read_o, mem_write_o,
             mem_addr_o, mem_wr_data_o, mem_size_o}, 74'h0);
        rst_ni = 1'b1;
        repeat (2) cycle();

        for (int i = 0; i < NVEC; i++) begin
            deny_q.delete();
            deny_q.push_back(tab[i].d0);
            deny_q.push_back(tab[i].d1);
            deny_q.push_back(tab[i].d2);
            deny_q.push_back(tab[i].d3);
            run_cmd($sformatf("vec%0d", i), tab[i].f3, tab[i].imm, tab[i].rs1, tab[i].rs2,
                    tab[i].busy, tab[i].done, tab[i].err, 1'b0);
        end

        chk("copy_dst_0x200", {rd(32'h200), rd(32'h204)}, {32'hA0A0_0001, 32'hB0B0_0002});
        chk("copy_dst_0x208", {rd(32'h208), rd(32'h20C)}, {32'hC0C0_0003, 32'hD0D0_0004});
        chk("wrap_second_write", rd(32'h0000_0000), 32'hB0B0_0002);
        chk("gnt_stall_data", {rd(32'h500), rd(32'h504)}, {32'h4444_0000, 32'h4444_0004});
        if (FILL_EN)
            chk("fill_0x308", rd(32'h308), 32'hDEAD_BEEF);
        else
            chk("no_fill_traffic", mem.exists(32'h300), 1'b0);

        // Command strobe while busy must be ignored
        run_cmd("en_while_busy", 3'b000, 12'd2, 32'h0000_0100, 32'h0000_0900, 6, 1, 0, 1'b1);

        // Reset asserted during the second word's write of a 4-word COPY
        mem[32'h600] = 32'h6000_0000;
        mem[32'h604] = 32'h6000_0004;
        mem[32'h608] = 32'h6000_0008;
        mem[32'h60C] = 32'h6000_000C;
        mem[32'h704] = 32'h5E5E_5E5E;
        wr_a.delete();
        wr_d.delete();
        dma_en_i = 1'b1;
        dma_funct3_i = 3'b000;
        dma_imm_i = 12'd4;
        dma_rs1_i = 32'h600;
        dma_rs2_i = 32'h700;
        cycle();
        dma_en_i = 1'b0;
        bb = 0;
        while (!(mem_write_o && wr_a.size() == 1) && bb < 100) begin
            cycle();
            bb++;
        end
        chk("reached_word2_write", {mem_write_o, mem_addr_o}, {1'b1, 32'h0000_0704});
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs",
            {dma_busy_o, dma_done_o, dma_err_o, mem_req_o, mem_read_o, mem_write_o,
             mem_addr_o, mem_wr_data_o, mem_size_o}, 74'h0);
        cycle();
        rst_ni = 1'b1;
        cycle();
        chk("abort_write_count", wr_a.size(), 1);
        chk("abort_left_memory", {rd(32'h700), rd(32'h704)}, {32'h6000_0000, 32'h5E5E_5E5E});
        run_cmd("post_reset_copy", 3'b000, 12'd1, 32'h0000_0608, 32'h0000_0780, 3, 1, 0, 1'b0);

        // Randomized commands against the word-level model
        for (int a = 0; a < 128; a++) mem[32'h1000 + 32'(a) * 32'd4] = $urandom;
        for (int t = 0; t < 40; t++) begin
            dd = $urandom_range(0, 9);
            if (dd < 6)      rf3 = 3'b000;
            else if (dd < 8) rf3 = 3'b001;
            else             rf3 = 3'($urandom_range(2, 7));
            rimm = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 6));
            if (rf3 == 3'b001) rrs1 = $urandom;
            else rrs1 = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            rrs2 = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            lg = legal(rf3);
            nreq = 0;
            eb = 0;
            if (lg && rimm != 12'd0) begin
                nreq = (rf3 == 3'b000) ? 2 * int'(rimm) : int'(rimm);
                eb = (rf3 == 3'b000) ? 3 * int'(rimm) : int'(rimm);
            end
            deny_q.delete();
            for (int k = 0; k < nreq; k++) begin
                dd = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                deny_q.push_back(dd);
                eb += dd;
            end
            run_cmd($sformatf("rnd%0d", t), rf3, rimm, rrs1, rrs2, eb, lg ? 1 : 0, lg ? 0 : 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
